// File: rtl/cpx_mon_pkg.sv
// Shared encodings for the CPX/PCX load monitor: packet type codes,
// per-thread load state and the sticky error code.
package cpx_mon_pkg;

    localparam logic [4:0] PCX_LOAD     = 5'b00000;
    localparam logic [3:0] CPX_LOAD_RET = 4'b0000;

    typedef enum logic [1:0] {
        ThrIdle   = 2'd0,
        ThrPendC  = 2'd1,
        ThrPendNc = 2'd2
    } thr_state_e;

    typedef enum logic [1:0] {
        ErrNone       = 2'd0,
        ErrDup        = 2'd1,
        ErrOrphan     = 2'd2,
        ErrNcMismatch = 2'd3
    } err_code_e;

endpackage

// File: rtl/thr_ld_fsm.sv
// One thread's outstanding-load record: evaluates a return against the old
// state, then applies a same-cycle request on top of the result.
module thr_ld_fsm
    import cpx_mon_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic req_nc,
    input  logic rtn,
    input  logic rtn_nc,
    output logic dup_err,
    output logic orphan_err,
    output logic nc_mismatch_err,
    output logic nc_done
);

    thr_state_e state_q, state_d, post_rtn;

    always_comb begin
        post_rtn        = state_q;
        dup_err         = 1'b0;
        orphan_err      = 1'b0;
        nc_mismatch_err = 1'b0;
        nc_done         = 1'b0;

        if (rtn) begin
            case (state_q)
                ThrIdle:   orphan_err = 1'b1;
                ThrPendNc: begin
                    nc_done         = rtn_nc;
                    nc_mismatch_err = !rtn_nc;
                    post_rtn        = ThrIdle;
                end
                ThrPendC:  begin
                    nc_mismatch_err = rtn_nc;
                    post_rtn        = ThrIdle;
                end
                default:   post_rtn = ThrIdle;
            endcase
        end

        state_d = post_rtn;
        // A request after a legal return sees IDLE, so it is not a duplicate.
        if (req) begin
            dup_err = (post_rtn != ThrIdle);
            state_d = req_nc ? ThrPendNc : ThrPendC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ThrIdle;
        else     state_q <= state_d;
    end

endmodule

// File: rtl/cpx_ld_rtn_tracker.sv
// Snoops one core's PCX load requests and CPX load returns, flags protocol
// errors and forwards the CPX return fields registered by one cycle.
module cpx_ld_rtn_tracker
    import cpx_mon_pkg::*;
#(
    parameter int unsigned   COREID = 0,
    parameter int unsigned   NTHR   = 2,
    localparam int unsigned  TW     = (NTHR > 1) ? $clog2(NTHR) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pcx_vld,
    input  logic [4:0]    pcx_rqtype,
    input  logic          pcx_nc,
    input  logic [TW-1:0] pcx_tid,
    input  logic          cpx_vld,
    input  logic [3:0]    cpx_rtntype,
    input  logic          cpx_nc,
    input  logic          cpx_wv,
    input  logic [TW-1:0] cpx_tid,
    output logic          out_vld,
    output logic [3:0]    out_rtntype,
    output logic          out_nc,
    output logic          out_wv,
    output logic [9:0]    out_coreid,
    output logic          err_pulse,
    output logic [1:0]    err_code,
    output logic [15:0]   nc_ld_cnt
);

    logic            req_ld, rtn_ld;
    logic [NTHR-1:0] dup_v, orphan_v, mism_v, done_v;

    assign req_ld = pcx_vld && (pcx_rqtype == PCX_LOAD);
    assign rtn_ld = cpx_vld && (cpx_rtntype == CPX_LOAD_RET);

    for (genvar i = 0; i < NTHR; i++) begin : g_thr
        thr_ld_fsm u_fsm (
            .clk             (clk),
            .rst             (rst),
            .req             (req_ld && (pcx_tid == TW'(i))),
            .req_nc          (pcx_nc),
            .rtn             (rtn_ld && (cpx_tid == TW'(i))),
            .rtn_nc          (cpx_nc),
            .dup_err         (dup_v[i]),
            .orphan_err      (orphan_v[i]),
            .nc_mismatch_err (mism_v[i]),
            .nc_done         (done_v[i])
        );
    end

    err_code_e err_code_q, err_code_d;
    logic      err_pulse_q;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        err_code_d = err_code_q;
        // Return-side errors outrank a coincident duplicate request.
        if (err_code_q == ErrNone) begin
            if (|orphan_v)    err_code_d = ErrOrphan;
            else if (|mism_v) err_code_d = ErrNcMismatch;
            else if (|dup_v)  err_code_d = ErrDup;
        end
        cnt_d = cnt_q;
        if ((|done_v) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_code_q  <= ErrNone;
            err_pulse_q <= 1'b0;
            cnt_q       <= '0;
            out_vld     <= 1'b0;
            out_rtntype <= '0;
            out_nc      <= 1'b0;
            out_wv      <= 1'b0;
        end else begin
            err_code_q  <= err_code_d;
            err_pulse_q <= |{dup_v, orphan_v, mism_v};
            cnt_q       <= cnt_d;
            out_vld     <= cpx_vld;
            out_rtntype <= cpx_rtntype;
            out_nc      <= cpx_nc;
            out_wv      <= cpx_wv;
        end
    end

    assign err_pulse  = err_pulse_q;
    assign err_code   = err_code_q;
    assign nc_ld_cnt  = cnt_q;
    assign out_coreid = 10'(COREID);

endmodule

// File: tb/tb_cpx_ld_rtn_tracker.sv
// Randomized and directed bench for cpx_ld_rtn_tracker against a
// per-thread outstanding-load scoreboard.
module tb_cpx_ld_rtn_tracker;

    localparam int unsigned COREID = 5;
    localparam int unsigned NTHR   = 2;
    localparam int unsigned TW     = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pcx_vld, pcx_nc, cpx_vld, cpx_nc, cpx_wv;
    logic [4:0]    pcx_rqtype;
    logic [3:0]    cpx_rtntype;
    logic [TW-1:0] pcx_tid, cpx_tid;
    logic          out_vld, out_nc, out_wv, err_pulse;
    logic [3:0]    out_rtntype;
    logic [9:0]    out_coreid;
    logic [1:0]    err_code;
    logic [15:0]   nc_ld_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Scoreboard: 0 = nothing outstanding, 1 = cacheable, 2 = non-cacheable.
    int          m_st[NTHR];
    int unsigned m_code, m_cnt;
    bit          m_pulse, m_vld, m_nc, m_wv;
    logic [3:0]  m_rt;

    cpx_ld_rtn_tracker #(.COREID(COREID), .NTHR(NTHR)) dut (
        .clk         (clk),
        .rst         (rst),
        .pcx_vld     (pcx_vld),
        .pcx_rqtype  (pcx_rqtype),
        .pcx_nc      (pcx_nc),
        .pcx_tid     (pcx_tid),
        .cpx_vld     (cpx_vld),
        .cpx_rtntype (cpx_rtntype),
        .cpx_nc      (cpx_nc),
        .cpx_wv      (cpx_wv),
        .cpx_tid     (cpx_tid),
        .out_vld     (out_vld),
        .out_rtntype (out_rtntype),
        .out_nc      (out_nc),
        .out_wv      (out_wv),
        .out_coreid  (out_coreid),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .nc_ld_cnt   (nc_ld_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_st[i]) m_st[i] = 0;
        m_code = 0; m_cnt = 0; m_pulse = 0;
        m_vld = 0; m_rt = '0; m_nc = 0; m_wv = 0;
    endtask

    // Drive one cycle of inputs, advance the scoreboard, then compare after the edge.
    task automatic step(input bit r, input bit pv, input logic [4:0] prq, input bit pn,
                        input int pt, input bit cv, input logic [3:0] crt, input bit cn,
                        input bit cw, input int ct, input bit chk);
        int unsigned rerr, derr;
        rst = r; pcx_vld = pv; pcx_rqtype = prq; pcx_nc = pn; pcx_tid = TW'(pt);
        cpx_vld = cv; cpx_rtntype = crt; cpx_nc = cn; cpx_wv = cw; cpx_tid = TW'(ct);
        rerr = 0; derr = 0;
        if (r) begin
            model_reset();
        end else begin
            if (cv && crt == 4'd0) begin
                if (m_st[ct] == 0) rerr = 2;
                else if ((m_st[ct] == 2) == cn) begin
                    if (m_st[ct] == 2 && m_cnt < 65535) m_cnt++;
                end else rerr = 3;
                m_st[ct] = 0;
            end
            if (pv && prq == 5'd0) begin
                if (m_st[pt] != 0) derr = 1;
                m_st[pt] = pn ? 2 : 1;
            end
            m_pulse = (rerr != 0) || (derr != 0);
            if (m_code == 0) m_code = (rerr != 0) ? rerr : derr;
            m_vld = cv; m_rt = crt; m_nc = cn; m_wv = cw;
        end
        @(posedge clk);
        #1;
        if (chk) begin
            check("out_vld", out_vld, m_vld);
            check("out_rtntype", out_rtntype, m_rt);
            check("out_nc", out_nc, m_nc);
            check("out_wv", out_wv, m_wv);
            check("out_coreid", out_coreid, COREID);
            check("err_pulse", err_pulse, m_pulse);
            check("err_code", err_code, m_code);
            check("nc_ld_cnt", nc_ld_cnt, m_cnt);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1);
    endtask

    initial begin
        model_reset();
        step(1, 0, 5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        step(1, 0, 5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1);
        check("reset_code", err_code, 0);
        check("reset_cnt", nc_ld_cnt, 0);

        // NC load on tid 0, legal return five cycles later.
        step(0, 1, 5'd0, 1, 0, 0, 4'd0, 0, 0, 0, 1);
        idle(4);
        step(0, 0, 5'd0, 0, 0, 1, 4'd0, 1, 0, 0, 1);
        check("t1_out_vld", out_vld, 1);
        check("t1_cnt", nc_ld_cnt, 1);
        check("t1_pulse", err_pulse, 0);
        idle(1);
        check("t1_out_vld_drop", out_vld, 0);

        // Cacheable load on tid 1 returned as NC.
        step(0, 1, 5'd0, 0, 1, 0, 4'd0, 0, 0, 0, 1);
        step(0, 0, 5'd0, 0, 0, 1, 4'd0, 1, 1, 1, 1);
        check("t2_pulse", err_pulse, 1);
        check("t2_code", err_code, 3);
        idle(1);
        check("t2_pulse_once", err_pulse, 0);
        step(0, 0, 5'd0, 0, 0, 1, 4'd0, 0, 0, 1, 1);
        check("t2_tid1_idle_orphan", err_pulse, 1);

        // Orphan first after reset, later duplicate keeps code 2.
        step(1, 0, 5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1);
        step(0, 0, 5'd0, 0, 0, 1, 4'd0, 0, 0, 0, 1);
        check("t3_code", err_code, 2);
        step(0, 1, 5'd0, 0, 1, 0, 4'd0, 0, 0, 0, 1);
        step(0, 1, 5'd0, 1, 1, 0, 4'd0, 0, 0, 0, 1);
        check("t3_dup_pulse", err_pulse, 1);
        check("t3_code_sticky", err_code, 2);

        // Same-cycle legal NC return and new cacheable request on tid 0.
        step(1, 0, 5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1);
        step(0, 1, 5'd0, 1, 0, 0, 4'd0, 0, 0, 0, 1);
        step(0, 1, 5'd0, 0, 0, 1, 4'd0, 1, 0, 0, 1);
        check("t4_no_err", err_pulse, 0);
        check("t4_cnt", nc_ld_cnt, 1);
        step(0, 0, 5'd0, 0, 0, 1, 4'd0, 0, 0, 0, 1);
        check("t4_pend_c", err_pulse, 0);

        // Reset coincident with a legal return on pending tid 1.
        step(0, 1, 5'd0, 0, 1, 0, 4'd0, 0, 0, 0, 1);
        step(1, 0, 5'd0, 0, 0, 1, 4'd0, 0, 1, 1, 1);
        check("t6_vld", out_vld, 0);
        check("t6_pulse", err_pulse, 0);
        step(0, 0, 5'd0, 0, 0, 1, 4'd0, 0, 0, 1, 1);
        check("t6_orphan", err_code, 2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit          r, pv, cv;
            logic [4:0]  prq;
            logic [3:0]  crt;
            r   = ($urandom_range(63) == 0);
            pv  = $urandom_range(1);
            cv  = $urandom_range(1);
            prq = ($urandom_range(3) == 0) ? 5'($urandom) : 5'd0;
            crt = ($urandom_range(3) == 0) ? 4'($urandom) : 4'd0;
            step(r, pv, prq, $urandom_range(1), $urandom_range(NTHR - 1),
                 cv, crt, $urandom_range(1), $urandom_range(1), $urandom_range(NTHR - 1), 1);
        end

        // Saturation: overlapped NC return + NC request on tid 0 every cycle.
        step(1, 0, 5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1);
        step(0, 1, 5'd0, 1, 0, 0, 4'd0, 0, 0, 0, 1);
        for (int i = 0; i < 65537; i++) step(0, 1, 5'd0, 1, 0, 1, 4'd0, 1, 0, 0, (i % 4096) == 0);
        step(0, 0, 5'd0, 0, 0, 1, 4'd0, 1, 0, 0, 1);
        check("t5_sat", nc_ld_cnt, 16'hFFFF);
        check("t5_no_err", err_code, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
